// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//   Fully pipelined barrel shifter. It supports SLL, SRL, SRA, ROL and ROR by
//   0..WIDTH-1, and in_mode values 101-111 pass the operand through
//   unchanged. Stage k shifts by 2^k when shamt bit k is set, starting with
//   the LSB stage. There are SHW = $clog2(WIDTH) stages, so the latency is
//   SHW cycles and the throughput is one operation per cycle.
//   All stages advance together on adv = out_ready || !out_valid.
//   Bubbles are not collapsed.
//
//   Optional macro BSH_OVF_EN adds the out_ovf port. It is a sticky flag
//   that is set when a 1-bit is shifted off the end in SLL, SRL or SRA.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    producer handshake (in_ready = adv)
//   in_data/in_shamt     operand and shift amount
//   in_mode              000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, else pass
//   out_valid/out_ready  consumer handshake
//   out_data, out_zero   result, and a flag that out_data == 0
//   out_ovf              shifted-out-ones flag (BSH_OVF_EN only)
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
`ifdef BSH_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of 2 and >= 2");
  end

  typedef enum logic [2:0] {
    MODE_SLL = 3'b000,
    MODE_SRL = 3'b001,
    MODE_SRA = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100
  } mode_e;

  logic             adv;
  logic [WIDTH-1:0] src_data  [SHW];
  logic [WIDTH-1:0] nxt_data  [SHW];
  logic [WIDTH-1:0] st_data   [SHW];
  logic [SHW-1:0]   src_shamt [SHW];
  logic [SHW-1:0]   st_shamt  [SHW];
  logic [2:0]       src_mode  [SHW];
  logic [2:0]       st_mode   [SHW];
  logic             src_valid [SHW];
  logic             st_valid  [SHW];
  logic             zero_q;

  // Every SRA stage fills from d[WIDTH-1]. Sign-filling keeps the MSB
  // unchanged, so the MSB seen by each stage is still the operand sign
  // captured when the operation was accepted.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [2:0]       m,
                                                  input int unsigned      s);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] r;
    ones = '1;
    case (m)
      MODE_SLL: r = d << s;
      MODE_SRL: r = d >> s;
      MODE_SRA: r = (d >> s) | (d[WIDTH-1] ? ~(ones >> s) : '0);
      MODE_ROL: r = (d << s) | (d >> (WIDTH - s));
      MODE_ROR: r = (d >> s) | (d << (WIDTH - s));
      default:  r = d;
    endcase
    return r;
  endfunction

  assign adv       = out_ready || !out_valid;
  assign in_ready  = adv;
  assign out_valid = st_valid[SHW-1];
  assign out_data  = st_data[SHW-1];
  assign out_zero  = zero_q;

  always_comb begin
    src_data  = '{default: '0};
    src_shamt = '{default: '0};
    src_mode  = '{default: '0};
    src_valid = '{default: 1'b0};
    nxt_data  = '{default: '0};
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_mode[0]  = in_mode;
    src_valid[0] = in_valid;
    for (int unsigned k = 1; k < SHW; k++) begin
      src_data[k]  = st_data[k-1];
      src_shamt[k] = st_shamt[k-1];
      src_mode[k]  = st_mode[k-1];
      src_valid[k] = st_valid[k-1];
    end
    for (int unsigned k = 0; k < SHW; k++) begin
      nxt_data[k] = src_shamt[k][k] ?
                    shift_step(src_data[k], src_mode[k], 32'd1 << k) :
                    src_data[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < SHW; k++) begin
        st_data[k]  <= '0;
        st_shamt[k] <= '0;
        st_mode[k]  <= '0;
        st_valid[k] <= 1'b0;
      end
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < SHW; k++) begin
        st_data[k]  <= nxt_data[k];
        st_shamt[k] <= src_shamt[k];
        st_mode[k]  <= src_mode[k];
        st_valid[k] <= src_valid[k];
      end
      zero_q <= (nxt_data[SHW-1] == '0);
    end
  end

`ifdef BSH_OVF_EN
  logic src_ovf [SHW];
  logic nxt_ovf [SHW];
  logic st_ovf  [SHW];

  // Bits lost by one stage: the top s bits for SLL, the bottom s bits for
  // SRL/SRA. Because the total shift is below WIDTH, these bits are always
  // original operand bits and never fill bits.
  function automatic logic lost_bits(input logic [WIDTH-1:0] d,
                                     input logic [2:0]       m,
                                     input int unsigned      s);
    logic l;
    case (m)
      MODE_SLL:           l = (d >> (WIDTH - s)) != '0;
      MODE_SRL, MODE_SRA: l = (d << (WIDTH - s)) != '0;
      default:            l = 1'b0;
    endcase
    return l;
  endfunction

  always_comb begin
    src_ovf = '{default: 1'b0};
    nxt_ovf = '{default: 1'b0};
    for (int unsigned k = 1; k < SHW; k++) src_ovf[k] = st_ovf[k-1];
    for (int unsigned k = 0; k < SHW; k++) begin
      nxt_ovf[k] = src_ovf[k] |
                   (src_shamt[k][k] & lost_bits(src_data[k], src_mode[k], 32'd1 << k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < SHW; k++) st_ovf[k] <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < SHW; k++) st_ovf[k] <= nxt_ovf[k];
    end
  end

  assign out_ovf = st_ovf[SHW-1];
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter
//   Runs two instances, WIDTH=8 and WIDTH=32, against a bit-level reference
//   model and in-order scoreboards. The WIDTH=8 instance gets the directed
//   scenarios. Both instances then get a randomized valid/ready run.
//   With BSH_OVF_EN defined, the bench also checks out_ovf.
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v8, r8, ov8, ordy8, oz8;
  logic [7:0]  d8, od8;
  logic [2:0]  sh8, m8;
  logic        v32, r32, ov32, ordy32, oz32;
  logic [31:0] d32, od32;
  logic [4:0]  sh32;
  logic [2:0]  m32;
`ifdef BSH_OVF_EN
  logic        ovf8, ovf32;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int pop8     = 0;
  int pop32    = 0;
  logic [32:0] q8[$];
  logic [32:0] q32[$];

  pipelined_barrel_shifter #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_data(d8),
    .in_shamt(sh8), .in_mode(m8), .out_valid(ov8), .out_ready(ordy8),
    .out_data(od8), .out_zero(oz8)
`ifdef BSH_OVF_EN
    , .out_ovf(ovf8)
`endif
  );

  pipelined_barrel_shifter #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .in_data(d32),
    .in_shamt(sh32), .in_mode(m32), .out_valid(ov32), .out_ready(ordy32),
    .out_data(od32), .out_zero(oz32)
`ifdef BSH_OVF_EN
    , .out_ovf(ovf32)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: each result bit is chosen from its source operand bit.
  // Returns {ovf, data}.
  function automatic logic [32:0] model(input int w, input logic [31:0] d,
                                        input int sh, input logic [2:0] m);
    logic [31:0] r;
    logic        ovf;
    r   = '0;
    ovf = 1'b0;
    for (int i = 0; i < w; i++) begin
      case (m)
        3'd0:    r[i] = (i >= sh) ? d[i-sh] : 1'b0;
        3'd1:    r[i] = (i + sh < w) ? d[i+sh] : 1'b0;
        3'd2:    r[i] = (i + sh < w) ? d[i+sh] : d[w-1];
        3'd3:    r[i] = d[(i - sh + w) % w];
        3'd4:    r[i] = d[(i + sh) % w];
        default: r[i] = d[i];
      endcase
    end
    if (m == 3'd0) for (int j = w - sh; j < w; j++) ovf |= d[j];
    if (m == 3'd1 || m == 3'd2) for (int j = 0; j < sh; j++) ovf |= d[j];
    return {ovf, r};
  endfunction

  task automatic observe();
    logic [32:0] e;
    if (ov8 && ordy8) begin
      chk("sb8_nonempty", q8.size() != 0, 1'b1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        pop8++;
        chk("data8", od8, e[7:0]);
        chk("zero8", oz8, e[7:0] == 8'h00);
`ifdef BSH_OVF_EN
        chk("ovf8", ovf8, e[32]);
`endif
      end
    end
    if (ov32 && ordy32) begin
      chk("sb32_nonempty", q32.size() != 0, 1'b1);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        pop32++;
        chk("data32", od32, e[31:0]);
        chk("zero32", oz32, e[31:0] == 32'h0);
`ifdef BSH_OVF_EN
        chk("ovf32", ovf32, e[32]);
`endif
      end
    end
    if (v8 && r8 && !rst)   q8.push_back(model(8, {24'h0, d8}, int'(sh8), m8));
    if (v32 && r32 && !rst) q32.push_back(model(32, d32, int'(sh32), m32));
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic commit();
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    commit();
  endtask

  task automatic op8(input logic [2:0] m, input logic [7:0] d, input logic [2:0] s);
    v8 = 1'b1; m8 = m; d8 = d; sh8 = s;
  endtask

  logic [2:0] b2b_m [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  logic [7:0] b2b_d [5] = '{8'hB5, 8'h96, 8'h81, 8'hB5, 8'h01};
  logic [2:0] b2b_s [5] = '{3'd3, 3'd6, 3'd1, 3'd4, 3'd0};
  logic [7:0] b2b_e [5] = '{8'h16, 8'hFE, 8'h03, 8'h5B, 8'h01};
  logic [2:0] bp_m  [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
  logic [7:0] bp_d  [4] = '{8'h3C, 8'hF0, 8'h12, 8'h80};
  logic [2:0] bp_s  [4] = '{3'd2, 3'd4, 3'd4, 3'd1};

  initial begin
    int j;
    int base;
    logic acc;

    rst = 1'b1;
    v8 = 1'b0; d8 = '0; sh8 = '0; m8 = '0; ordy8 = 1'b0;
    v32 = 1'b0; d32 = '0; sh32 = '0; m32 = '0; ordy32 = 1'b1;

    // Reset state. in_ready must be 1 even with out_ready low.
    sample();
    chk("rst_out_valid", ov8, 1'b0);
    chk("rst_out_data", od8, 8'h00);
    chk("rst_out_zero", oz8, 1'b0);
    chk("rst_in_ready", r8, 1'b1);
`ifdef BSH_OVF_EN
    chk("rst_out_ovf", ovf8, 1'b0);
`endif
    commit();
    rst = 1'b0;
    ordy8 = 1'b1;
    step();

    // SLL 0xB5 by 5: the result appears exactly 3 cycles after the accept cycle.
    op8(3'd0, 8'hB5, 3'd5);
    step();
    v8 = 1'b0;
    sample(); chk("lat_c1", ov8, 1'b0); commit();
    sample(); chk("lat_c2", ov8, 1'b0); commit();
    sample();
    chk("lat_c3_valid", ov8, 1'b1);
    chk("sll_data", od8, 8'hA0);
    chk("sll_zero", oz8, 1'b0);
`ifdef BSH_OVF_EN
    chk("sll_ovf", ovf8, 1'b1);
`endif
    commit();

    // Five back-to-back operations, whose results must come out on five
    // consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      if (i < 5) op8(b2b_m[i], b2b_d[i], b2b_s[i]); else v8 = 1'b0;
      sample();
      if (i < 3) chk("b2b_idle", ov8, 1'b0);
      else begin
        chk("b2b_valid", ov8, 1'b1);
        chk("b2b_data", od8, b2b_e[i-3]);
      end
      commit();
    end

    // Backpressure: out_ready stays low while 4 operations are offered.
    ordy8 = 1'b0;
    j = 0;
    base = pop8;
    for (int c = 0; c < 8; c++) begin
      if (j < 4) op8(bp_m[j], bp_d[j], bp_s[j]); else v8 = 1'b0;
      sample();
      acc = v8 && r8;
      if (c >= 3) begin
        chk("bp_hold_valid", ov8, 1'b1);
        chk("bp_hold_data", od8, 8'hF0);
        chk("bp_in_ready", r8, 1'b0);
      end
      commit();
      if (acc) j++;
    end
    ordy8 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (j < 4) op8(bp_m[j], bp_d[j], bp_s[j]); else v8 = 1'b0;
      sample();
      acc = v8 && r8;
      commit();
      if (acc) j++;
      if (j == 4 && pop8 - base == 4) break;
    end
    v8 = 1'b0;
    chk("bp_accepted", j, 4);
    chk("bp_drained", pop8 - base, 4);
    chk("bp_sb_empty", q8.size(), 0);

    // A zero result, followed by a pass-through mode.
    for (int i = 0; i < 5; i++) begin
      if (i == 0) op8(3'd1, 8'h0F, 3'd7);
      else if (i == 1) op8(3'b110, 8'h5A, 3'd3);
      else v8 = 1'b0;
      sample();
      if (i == 3) begin
        chk("srl_zero_data", od8, 8'h00);
        chk("srl_zero_flag", oz8, 1'b1);
`ifdef BSH_OVF_EN
        chk("srl_zero_ovf", ovf8, 1'b1);
`endif
      end
      if (i == 4) begin
        chk("pass_data", od8, 8'h5A);
        chk("pass_zero", oz8, 1'b0);
      end
      commit();
    end

    // Reset while two operations are in flight: neither may ever appear.
    op8(3'd1, 8'hFF, 3'd1); step();
    op8(3'd3, 8'h0F, 3'd2); step();
    v8 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    q8.delete();
    q32.delete();
    for (int c = 0; c < 5; c++) begin
      sample(); chk("rst_flush", ov8, 1'b0); commit();
    end
    op8(3'd0, 8'h01, 3'd7);
    step();
    v8 = 1'b0;
    sample(); chk("post_rst_c1", ov8, 1'b0); commit();
    sample(); chk("post_rst_c2", ov8, 1'b0); commit();
    sample();
    chk("post_rst_valid", ov8, 1'b1);
    chk("post_rst_data", od8, 8'h80);
    commit();

    // Random traffic on both widths with random stalls.
    for (int c = 0; c < 16000; c++) begin
      v8    = ($urandom_range(0, 3) != 0);
      d8    = 8'($urandom);
      sh8   = 3'($urandom);
      m8    = 3'($urandom_range(0, 7));
      ordy8 = ($urandom_range(0, 3) != 0);
      v32    = ($urandom_range(0, 3) != 0);
      d32    = $urandom;
      sh32   = 5'($urandom);
      m32    = 3'($urandom_range(0, 7));
      ordy32 = ($urandom_range(0, 3) != 0);
      step();
    end
    v8 = 1'b0; v32 = 1'b0; ordy8 = 1'b1; ordy32 = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (q8.size() == 0 && q32.size() == 0) break;
      step();
    end
    chk("final_sb8_empty", q8.size(), 0);
    chk("final_sb32_empty", q32.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, fully pipelined barrel shifter with a run-time selectable operation: logical left, logical right, arithmetic right, rotate left and rotate right, by any amount 0..WIDTH-1. It is the clocked, generalised successor of the team's fixed-amount 8-bit combinational shifter. It sits between a valid/ready producer (ALU operand path) and a valid/ready consumer, and accepts one operation per cycle. One log2 shift stage is registered per pipeline stage.

Parameters:
WIDTH, 8, data width; must be a power of 2 and >= 2 (elaboration error otherwise)
SHW, $clog2(WIDTH), localparam: shift-amount width and pipeline depth (LAT = SHW cycles)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation offered
in_ready  output  1  operation accepted when in_valid && in_ready
in_data  input  WIDTH  operand
in_shamt  input  SHW  shift/rotate amount
in_mode  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through
out_valid  output  1  result available
out_ready  input  1  consumer accepts when out_valid && out_ready
out_data  output  WIDTH  result
out_zero  output  1  out_data == 0, registered with the result

Behaviour:
- Reset: synchronous, active-high; all stage valid bits, out_valid, out_data, out_zero = 0 on the first clk edge with rst=1. Reset mid-operation discards every in-flight op; no partial result emerges. in_ready = 1 during and after reset (out_valid=0).
- Pipeline: stage k (k=0..SHW-1) conditionally shifts/rotates by 2^k when shamt bit k is 1, LSB stage first. Each stage register carries data, remaining shamt bits, mode and valid. The last stage drives out_*.
- Latency: exactly SHW cycles from the accept edge to out_valid=1 with no stall (WIDTH=8: 3 cycles). Throughput: 1 op/cycle.
- Flow control: global enable adv = out_ready || !out_valid. in_ready = adv (combinational). When adv=0, all stages hold. Bubbles are not collapsed.
- Ordering: results leave strictly in acceptance order. No op is dropped or duplicated under any out_ready pattern.
- Fill rules: SLL zero-fills the LSBs. SRL zero-fills the MSBs. SRA replicates the operand MSB (sign captured at accept, carried through). ROL/ROR wrap bits end-around.
- shamt = 0 gives out_data = in_data for every mode. Pass-through modes ignore shamt.
- out_zero is valid only while out_valid=1.
- Simultaneous accept and emit in one cycle is legal and required at full rate.

Optional Feature:
BSH_OVF_EN: adds output out_ovf (1 bit), registered alongside out_data.
- SLL and SRL/SRA: out_ovf = 1 if any 1-bit was shifted off the end. For SRA, the discarded bits are the original LSBs. The flag is a sticky OR accumulated per stage.
- Rotates and pass-through: out_ovf = 0.
- out_ovf resets to 0.
Without the macro: no out_ovf port, no sticky logic, and all other behaviour is identical.

Test Plan:
- WIDTH=8, SLL, in_data=8'hB5, shamt=5, out_ready=1 -> out_data=8'hA0 exactly 3 cycles after accept; out_zero=0; out_ovf=1 if enabled.
- Back-to-back over 5 cycles: SRL 8'hB5 by 3, SRA 8'h96 by 6, ROL 8'h81 by 1, ROR 8'hB5 by 4, SLL 8'h01 by 0 -> 8'h16, 8'hFE, 8'h03, 8'h5B, 8'h01 on 5 consecutive cycles, in order.
- Backpressure: hold out_ready=0 while issuing 4 ops -> out_valid stays 1 holding the first result and in_ready=0. Release out_ready -> all 4 results drain in order, none lost or duplicated.
- Zero/pass: SRL 8'h0F by 7 -> out_data=8'h00, out_zero=1. Mode 3'b110 with 8'h5A, shamt 3 -> 8'h5A.
- Reset mid-flight: accept 2 ops, assert rst for 1 cycle before either emerges -> out_valid=0 next cycle and neither result ever appears. A new op after reset emerges 3 cycles after its accept.
- Random with a reference model, WIDTH=8 and WIDTH=32, random in_valid/out_ready, 10k ops -> all results and flags match, in order.
